alu_status_reg: RTL and testbench

Result/flag stage directly downstream of the ALU: registers the ALU result into the adder hold register, applies BCD decimal correction when decimal mode is active, and maintains the processor status register P (N V D I Z C). It is the sole owner of P. It accepts flag updates from the ALU, explicit set/clear micro-ops (SEC/CLC, SEI/CLI, SED/CLD, CLV) and whole-register loads (PLP/RTI). Its D output feeds the ALU's BCDS input.

---
 rtl/alu_status_reg_pkg.sv | 15 +
 rtl/alu_status_reg_bcd_adjust.sv | 29 ++
 rtl/alu_status_reg.sv | 85 ++++++++
 tb/tb_alu_status_reg.sv | 100 ++++++++++
 4 files changed

// File: rtl/alu_status_reg_pkg.sv
// alu_status_reg_pkg: P bit indices, reset value and BCD correction constants.
package alu_status_reg_pkg;
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;
    localparam logic [7:0] P_RESET = 8'h24;
    localparam logic [7:0] BCD_06 = 8'h06;
    localparam logic [7:0] BCD_60 = 8'h60;
    localparam logic [7:0] BCD_9F = 8'h9F;
endpackage

// File: rtl/alu_status_reg_bcd_adjust.sv
// bcd_adjust: decimal correction of an ALU result.
// Ports: result/hcout/cout from the ALU, dec_add/dec_sub select the correction
// (dec_add wins), adj is the corrected byte, c_new the resulting carry.
module bcd_adjust
    import alu_status_reg_pkg::*;
(
    input  logic [7:0] result,
    input  logic       hcout,
    input  logic       cout,
    input  logic       dec_add,
    input  logic       dec_sub,
    output logic [7:0] adj,
    output logic       c_new
);
    logic [7:0] lo_fix;
    logic       hi_add;
    always_comb begin
        lo_fix = (hcout || result[3:0] > 4'd9) ? result + BCD_06 : result;
        hi_add = cout || lo_fix > BCD_9F;
        adj    = result;
        c_new  = cout;
        if (dec_add) begin
            adj   = hi_add ? lo_fix + BCD_60 : lo_fix;
            c_new = hi_add;
        end else if (dec_sub) begin
            adj = result - (hcout ? 8'h00 : BCD_06) - (cout ? 8'h00 : BCD_60);
        end
    end
endmodule

// File: rtl/alu_status_reg.sv
// alu_status_reg: ALU result hold register with BCD correction and status register P.
// Ports: CLK/RST; ALU inputs RESULT OF Cout HCout ALU_VALID DEC_ADD DEC_SUB UPD_*;
// flag micro-ops SET_*/CLR_*; P_LOAD/P_IN whole-register load; PUSH_BRK drives P[4];
// outputs ADD, VALID_OUT, P and D_FLAG.
module alu_status_reg
    import alu_status_reg_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] RESULT,
    input  logic       OF,
    input  logic       Cout,
    input  logic       HCout,
    input  logic       ALU_VALID,
    input  logic       DEC_ADD,
    input  logic       DEC_SUB,
    input  logic       UPD_NZ,
    input  logic       UPD_C,
    input  logic       UPD_V,
    input  logic       SET_C,
    input  logic       CLR_C,
    input  logic       SET_I,
    input  logic       CLR_I,
    input  logic       SET_D,
    input  logic       CLR_D,
    input  logic       CLR_V,
    input  logic       P_LOAD,
    input  logic [7:0] P_IN,
    input  logic       PUSH_BRK,
    output logic [7:0] ADD,
    output logic       VALID_OUT,
    output logic [7:0] P,
    output logic       D_FLAG
);
    logic [7:0] add_q, add_d, adj;
    logic       valid_q, valid_d, c_new;
    logic       n_q, n_d, v_q, v_d, d_q, d_d, i_q, i_d, z_q, z_d, c_q, c_d;
    logic       unused_p_in;
    assign unused_p_in = ^P_IN[P_U:P_B];
    bcd_adjust u_bcd (
        .result (RESULT),
        .hcout  (HCout),
        .cout   (Cout),
        .dec_add(d_q && DEC_ADD),
        .dec_sub(d_q && DEC_SUB && !DEC_ADD),
        .adj    (adj),
        .c_new  (c_new)
    );
    // Priority per flag: P_LOAD, then CLR, then SET, then the ALU source.
    always_comb begin
        add_d   = ALU_VALID ? adj : add_q;
        valid_d = ALU_VALID;
        n_d = P_LOAD ? P_IN[P_N] : (ALU_VALID && UPD_NZ) ? adj[7] : n_q;
        z_d = P_LOAD ? P_IN[P_Z] : (ALU_VALID && UPD_NZ) ? (adj == 8'h00) : z_q;
        v_d = P_LOAD ? P_IN[P_V] : CLR_V ? 1'b0 : (ALU_VALID && UPD_V) ? OF : v_q;
        c_d = P_LOAD ? P_IN[P_C] : CLR_C ? 1'b0 : SET_C ? 1'b1 : (ALU_VALID && UPD_C) ? c_new : c_q;
        i_d = P_LOAD ? P_IN[P_I] : CLR_I ? 1'b0 : SET_I ? 1'b1 : i_q;
        d_d = P_LOAD ? P_IN[P_D] : CLR_D ? 1'b0 : SET_D ? 1'b1 : d_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            add_q   <= 8'h00;
            valid_q <= 1'b0;
            n_q     <= P_RESET[P_N];
            v_q     <= P_RESET[P_V];
            d_q     <= P_RESET[P_D];
            i_q     <= P_RESET[P_I];
            z_q     <= P_RESET[P_Z];
            c_q     <= P_RESET[P_C];
        end else begin
            add_q   <= add_d;
            valid_q <= valid_d;
            n_q     <= n_d;
            v_q     <= v_d;
            d_q     <= d_d;
            i_q     <= i_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end
    assign ADD       = add_q;
    assign VALID_OUT = valid_q;
    assign D_FLAG    = d_q;
    assign P         = {n_q, v_q, 1'b1, PUSH_BRK, d_q, i_q, z_q, c_q};
endmodule

// File: tb/tb_alu_status_reg.sv
// tb_alu_status_reg: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_alu_status_reg;
    logic       CLK = 0, RST = 1;
    logic [7:0] RESULT = 0, P_IN = 0;
    logic       OF = 0, Cout = 0, HCout = 0, ALU_VALID = 0, DEC_ADD = 0, DEC_SUB = 0;
    logic       UPD_NZ = 0, UPD_C = 0, UPD_V = 0;
    logic       SET_C = 0, CLR_C = 0, SET_I = 0, CLR_I = 0, SET_D = 0, CLR_D = 0, CLR_V = 0;
    logic       P_LOAD = 0, PUSH_BRK = 0;
    logic [7:0] ADD, P;
    logic       VALID_OUT, D_FLAG;
    int         total = 0, bad = 0;
    logic [16:0] sb[$];

    alu_status_reg dut (
        .CLK(CLK), .RST(RST), .RESULT(RESULT), .OF(OF), .Cout(Cout), .HCout(HCout),
        .ALU_VALID(ALU_VALID), .DEC_ADD(DEC_ADD), .DEC_SUB(DEC_SUB),
        .UPD_NZ(UPD_NZ), .UPD_C(UPD_C), .UPD_V(UPD_V),
        .SET_C(SET_C), .CLR_C(CLR_C), .SET_I(SET_I), .CLR_I(CLR_I),
        .SET_D(SET_D), .CLR_D(CLR_D), .CLR_V(CLR_V),
        .P_LOAD(P_LOAD), .P_IN(P_IN), .PUSH_BRK(PUSH_BRK),
        .ADD(ADD), .VALID_OUT(VALID_OUT), .P(P), .D_FLAG(D_FLAG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from input changes.
    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            automatic logic [16:0] e = sb.pop_front();
            chk("ADD", ADD, e[16:9]);
            chk("VALID_OUT", {7'd0, VALID_OUT}, {7'd0, e[8]});
            chk("P", P, e[7:0]);
            chk("D_FLAG", {7'd0, D_FLAG}, {7'd0, e[3]});
        end
    end

    task automatic idle();
        RST = 0; ALU_VALID = 0; DEC_ADD = 0; DEC_SUB = 0; UPD_NZ = 0; UPD_C = 0; UPD_V = 0;
        SET_C = 0; CLR_C = 0; SET_I = 0; CLR_I = 0; SET_D = 0; CLR_D = 0; CLR_V = 0;
        P_LOAD = 0; OF = 0; Cout = 0; HCout = 0;
    endtask

    task automatic tick(input logic [7:0] ea, input logic ev, input logic [7:0] ep);
        @(posedge CLK);
        sb.push_back({ea, ev, ep});
        @(negedge CLK);
        #1;
        idle();
    endtask

    initial begin
        RST = 1; tick(8'h00, 0, 8'h24);
        RST = 1; tick(8'h00, 0, 8'h24);
        RESULT = 8'h80; OF = 1; ALU_VALID = 1; UPD_NZ = 1; UPD_C = 1; UPD_V = 1;
        tick(8'h80, 1, 8'hE4);
        tick(8'h80, 0, 8'hE4);
        SET_D = 1; tick(8'h80, 0, 8'hEC);
        RESULT = 8'h41; HCout = 1; ALU_VALID = 1; DEC_ADD = 1; UPD_NZ = 1; UPD_C = 1;
        tick(8'h47, 1, 8'h6C);
        RESULT = 8'h9A; ALU_VALID = 1; DEC_ADD = 1; UPD_NZ = 1; UPD_C = 1;
        tick(8'h00, 1, 8'h6F);
        RESULT = 8'h0F; Cout = 1; ALU_VALID = 1; DEC_SUB = 1; UPD_NZ = 1; UPD_C = 1;
        tick(8'h09, 1, 8'h6D);
        CLR_D = 1; tick(8'h09, 0, 8'h65);
        RESULT = 8'h9A; ALU_VALID = 1; DEC_ADD = 1; UPD_NZ = 1; UPD_C = 1;
        tick(8'h9A, 1, 8'hE4);
        CLR_V = 1; tick(8'h9A, 0, 8'hA4);
        P_IN = 8'hFF; P_LOAD = 1; RESULT = 8'h00; ALU_VALID = 1; UPD_NZ = 1;
        tick(8'h00, 1, 8'hEF);
        CLR_C = 1; tick(8'h00, 0, 8'hEE);
        RESULT = 8'h12; SET_C = 1; ALU_VALID = 1; UPD_C = 1;
        tick(8'h12, 1, 8'hEF);
        SET_I = 1; CLR_I = 1; tick(8'h12, 0, 8'hEB);
        SET_C = 1; CLR_C = 1; tick(8'h12, 0, 8'hEA);
        P_IN = 8'h30; P_LOAD = 1; tick(8'h12, 0, 8'h20);
        RESULT = 8'h33; ALU_VALID = 1; tick(8'h33, 1, 8'h20);
        RST = 1; RESULT = 8'h55; ALU_VALID = 1; UPD_NZ = 1; SET_D = 1;
        tick(8'h00, 0, 8'h24);
        PUSH_BRK = 1; tick(8'h00, 0, 8'h34);
        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1);
    end
endmodule
